// File: rtl/data_ram_responder_pkg.sv
// rtl/data_ram_responder_pkg.sv - shared FSM state codes, constants and helpers for data_ram_responder
// Purpose: common definitions for the CPU data-memory responder.
//   state_t       responder FSM states (INIT zero-fill, IDLE, RWAIT load wait)
//   OOR_RDATA     value returned by a load outside the mapped window
//   rdLatLegal()  true when a read latency lies in the supported 1..4 range
package data_ram_responder_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RWAIT = 2'd2
  } state_t;

  localparam logic [31:0] OOR_RDATA = 32'h0;

  function automatic bit rdLatLegal(input int lat);
    return (lat >= 1) && (lat <= 4);
  endfunction

endpackage

// File: rtl/data_ram_responder_byte_lane_ram.sv
// rtl/data_ram_responder_byte_lane_ram.sv - 4 x 8-bit lane SRAM with per-lane write enable and registered read
// Purpose: word-addressed storage for the data-memory responder.
// Ports:
//   clk     in   clock
//   laneWe  in   4     per-lane synchronous write enable; laneWe[i] writes wdata[8i+7:8i]
//   addr    in   AW    word address shared by read and write
//   wdata   in   32    write data
//   re      in   1     read enable; rdata updates only on an enabled edge, otherwise holds
//   rdata   out  32    registered read data
module data_ram_responder_byte_lane_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [3:0]    laneWe,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem [0:(2**AW)-1];
    logic [7:0] q;

    always_ff @(posedge clk) begin
      if (laneWe[i]) mem[addr] <= wdata[8*i +: 8];
      if (re)        q         <= mem[addr];
    end

    assign rdata[8*i +: 8] = q;
  end

endmodule

// File: rtl/data_ram_responder.sv
// rtl/data_ram_responder.sv - CPU data-memory responder: byte-enable SRAM, read latency, zero-fill, range error
// Purpose: services core load/store requests against a word-addressed SRAM window at BASE.
// Ports:
//   clk     in   1    clock, rising edge
//   rst     in   1    asynchronous active-low reset
//   req     in   1    access request, held stable with its fields while busy=1
//   we      in   1    1 = store, 0 = load
//   sel     in   4    byte-lane enables for stores
//   addr    in   32   byte address; addr[1:0] ignored
//   wdata   in   32   lane-aligned store data
//   rdata   out  32   load data, held until the next load completes
//   rvalid  out  1    one-cycle pulse when load data is available
//   busy    out  1    stall: zero-fill in progress or load wait
//   err     out  1    sticky out-of-range access flag, cleared only by reset
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int          AW           = 10,
  parameter int          RD_LAT       = 1,
  parameter int          CLEAR_ON_RST = 1,
  parameter logic [31:0] BASE         = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        busy,
  output logic        err
);

  if (!rdLatLegal(RD_LAT)) begin : g_bad_lat
    $error("data_ram_responder: RD_LAT must be 1..4");
  end

  localparam logic [AW:0] LAST_WORD = (AW+1)'((2**AW) - 1);
  localparam logic [1:0]  LAT_INIT  = 2'(RD_LAT - 1);
  localparam state_t      RST_STATE = (CLEAR_ON_RST != 0) ? ST_INIT : ST_IDLE;

  state_t        state, stateNext;
  logic [AW:0]   cnt, cntNext;
  logic [1:0]    waitCnt, waitNext;
  logic          loadOor;
  logic          accept, loadDone;

  logic [31:0]   offset;
  logic          inRange;
  logic [AW-1:0] reqIdx;

  logic [3:0]    ramWe;
  logic [AW-1:0] ramAddr;
  logic [31:0]   ramWdata;
  logic          ramRe;
  logic [31:0]   ramQ;

  // Window check on the offset from BASE: anything at or above 4*2**AW
  // (including wrap-around below BASE) is out of range.
  assign offset  = addr - BASE;
  assign inRange = (offset >> (AW + 2)) == 32'd0;
  assign reqIdx  = offset[AW+1:2];

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    waitNext  = waitCnt;
    ramWe     = 4'b0000;
    ramAddr   = reqIdx;
    ramWdata  = wdata;
    ramRe     = 1'b0;
    accept    = 1'b0;
    loadDone  = 1'b0;
    busy      = 1'b1;
    unique case (state)
      ST_INIT: begin
        ramWe    = 4'hF;
        ramAddr  = cnt[AW-1:0];
        ramWdata = 32'h0;
        cntNext  = cnt + 1'b1;
        if (cnt == LAST_WORD) stateNext = ST_IDLE;
      end
      ST_IDLE: begin
        busy = 1'b0;
        if (req) begin
          if (we) begin
            ramWe = inRange ? sel : 4'b0000;
          end else begin
            // The RAM is read on the accepting edge; its output register
            // then holds steady through the wait states.
            ramRe     = 1'b1;
            accept    = 1'b1;
            waitNext  = LAT_INIT;
            stateNext = ST_RWAIT;
          end
        end
      end
      ST_RWAIT: begin
        if (waitCnt == 2'd0) begin
          loadDone  = 1'b1;
          stateNext = ST_IDLE;
        end else begin
          waitNext = waitCnt - 1'b1;
        end
      end
      default: stateNext = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RST_STATE;
      cnt     <= '0;
      waitCnt <= '0;
      loadOor <= 1'b0;
      rdata   <= '0;
      rvalid  <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      waitCnt <= waitNext;
      rvalid  <= loadDone;
      if (accept)   loadOor <= !inRange;
      if (loadDone) rdata   <= loadOor ? OOR_RDATA : ramQ;
      if (state == ST_IDLE && req && !inRange) err <= 1'b1;
    end
  end

  data_ram_responder_byte_lane_ram #(.AW(AW)) uRam (
    .clk    (clk),
    .laneWe (ramWe),
    .addr   (ramAddr),
    .wdata  (ramWdata),
    .re     (ramRe),
    .rdata  (ramQ)
  );

endmodule

// File: tb/tb_data_ram_responder.sv
// tb/tb_data_ram_responder.sv - self-checking bench for data_ram_responder
module tb_data_ram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, we;
  logic [3:0]  sel;
  logic [31:0] addr, wdata;
  int          which;

  logic reqA, reqB, reqC;
  assign reqA = req && (which == 0);
  assign reqB = req && (which == 1);
  assign reqC = req && (which == 2);

  logic [31:0] rdA, rdB, rdC;
  logic        rvA, rvB, rvC, bzA, bzB, bzC, erA, erB, erC;

  data_ram_responder #(.AW(4), .RD_LAT(1), .CLEAR_ON_RST(1), .BASE(32'h0)) dutA (
    .clk(clk), .rst(rst), .req(reqA), .we(we), .sel(sel), .addr(addr), .wdata(wdata),
    .rdata(rdA), .rvalid(rvA), .busy(bzA), .err(erA));
  data_ram_responder #(.AW(4), .RD_LAT(3), .CLEAR_ON_RST(1), .BASE(32'h0)) dutB (
    .clk(clk), .rst(rst), .req(reqB), .we(we), .sel(sel), .addr(addr), .wdata(wdata),
    .rdata(rdB), .rvalid(rvB), .busy(bzB), .err(erB));
  data_ram_responder #(.AW(4), .RD_LAT(2), .CLEAR_ON_RST(0), .BASE(32'h0)) dutC (
    .clk(clk), .rst(rst), .req(reqC), .we(we), .sel(sel), .addr(addr), .wdata(wdata),
    .rdata(rdC), .rvalid(rvC), .busy(bzC), .err(erC));

  logic [31:0] rdata;
  logic        rvalid, busy, err;
  always_comb begin
    rdata = rdA; rvalid = rvA; busy = bzA; err = erA;
    if (which == 1) begin rdata = rdB; rvalid = rvB; busy = bzB; err = erB; end
    if (which == 2) begin rdata = rdC; rvalid = rvC; busy = bzC; err = erC; end
  end

  int nChecks = 0;
  int nPass   = 0;
  logic cFirst;
  logic rvSeen;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic doStore(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b1; sel = s; addr = a; wdata = d;
    @(posedge clk); #1;
  endtask

  task automatic doLoad(input string nm, input logic [31:0] a, input logic [31:0] exp, input int lat);
    int k;
    int stall;
    bit got;
    @(negedge clk);
    req = 1'b1; we = 1'b0; sel = 4'hF; addr = a; wdata = 32'h0;
    @(posedge clk); #1;
    k = 0; stall = 0; got = 0;
    if (busy) stall++;
    while (!got && k < 10) begin
      @(posedge clk); #1;
      k++;
      if (rvalid) got = 1;
      else if (busy) stall++;
    end
    check({nm, "_lat"}, k, lat);
    check({nm, "_stall"}, stall, lat);
    check({nm, "_rdata"}, rdata, exp);
    check({nm, "_busy_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    check({nm, "_pulse"}, 32'(rvalid), 32'd0);
    check({nm, "_hold"}, rdata, exp);
  endtask

  task automatic idle();
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic countFill(output int n);
    bit done;
    done = 0; n = 0; rvSeen = 1'b0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) cFirst = bzC;
      if (rvalid) rvSeen = 1'b1;
      if (!busy) done = 1;
    end
  endtask

  typedef struct {
    logic        isLoad;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
    logic        expErr;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];
  int   latOf [3];

  initial begin
    int n;
    rst = 1'b0; req = 1'b0; we = 1'b0; sel = 4'h0; addr = 32'h0; wdata = 32'h0; which = 0;
    cFirst = 1'b1; rvSeen = 1'b0;
    latOf[0] = 1; latOf[1] = 3; latOf[2] = 2;

    tbl[0]  = '{1'b0, 4'hF, 32'h0000_0008, 32'hA1B2C3D4, 1'b0};
    tbl[1]  = '{1'b0, 4'h2, 32'h0000_0008, 32'h0000EE00, 1'b0};
    tbl[2]  = '{1'b1, 4'hF, 32'h0000_0008, 32'hA1B2EED4, 1'b0};
    tbl[3]  = '{1'b0, 4'hF, 32'h0000_0004, 32'h12345678, 1'b0};
    tbl[4]  = '{1'b1, 4'hF, 32'h0000_0004, 32'h12345678, 1'b0};
    tbl[5]  = '{1'b0, 4'h0, 32'h0000_0004, 32'hFFFFFFFF, 1'b0};
    tbl[6]  = '{1'b1, 4'hF, 32'h0000_0004, 32'h12345678, 1'b0};
    tbl[7]  = '{1'b0, 4'hF, 32'h0000_000C, 32'h11223344, 1'b0};
    tbl[8]  = '{1'b0, 4'h1, 32'h0000_000C, 32'h000000AB, 1'b0};
    tbl[9]  = '{1'b1, 4'hF, 32'h0000_000C, 32'h112233AB, 1'b0};
    tbl[10] = '{1'b0, 4'hF, 32'h0000_003C, 32'hDEADBEEF, 1'b0};
    tbl[11] = '{1'b1, 4'hF, 32'h0000_003F, 32'hDEADBEEF, 1'b0};
    tbl[12] = '{1'b0, 4'hF, 32'h0000_0000, 32'h0BADF00D, 1'b0};
    tbl[13] = '{1'b1, 4'hF, 32'h0000_0040, 32'h00000000, 1'b1};
    tbl[14] = '{1'b0, 4'hF, 32'h0000_0040, 32'hFFFFFFFF, 1'b1};
    tbl[15] = '{1'b1, 4'hF, 32'h0000_0000, 32'h0BADF00D, 1'b1};
    tbl[16] = '{1'b0, 4'hF, 32'hFFFF_FFFC, 32'h55555555, 1'b1};
    tbl[17] = '{1'b1, 4'hF, 32'h0000_0008, 32'hA1B2EED4, 1'b1};
    tbl[18] = '{1'b1, 4'hF, 32'h0000_003C, 32'hDEADBEEF, 1'b1};

    // reset state
    #12;
    check("rst_busyA", 32'(bzA), 32'd1);
    check("rst_busyC", 32'(bzC), 32'd0);
    check("rst_rdataA", rdA, 32'h0);
    check("rst_rvalidA", 32'(rvA), 32'd0);
    check("rst_errA", 32'(erA), 32'd0);

    // zero-fill length
    @(negedge clk); rst = 1'b1;
    which = 0;
    countFill(n);
    check("fill_len", n, 32'd16);
    check("fill_busyB", 32'(bzB), 32'd0);
    check("c_first_busy", 32'(cFirst), 32'd0);
    check("fill_no_rvalid", 32'(rvSeen), 32'd0);

    doLoad("clrA", 32'h1C, 32'h0, 1);
    which = 1;
    doLoad("clrB", 32'h1C, 32'h0, 3);

    // table-driven store/load vectors on each configuration
    for (int d = 0; d < 3; d++) begin
      which = d;
      for (int v = 0; v < NV; v++) begin
        if (tbl[v].isLoad) doLoad($sformatf("d%0d_v%0d", d, v), tbl[v].addr, tbl[v].data, latOf[d]);
        else doStore(tbl[v].addr, tbl[v].sel, tbl[v].data);
        check($sformatf("d%0d_v%0d_err", d, v), 32'(err), 32'(tbl[v].expErr));
      end
      idle();
    end

    // reset in the middle of a RD_LAT=3 load
    which = 1;
    @(negedge clk);
    req = 1'b1; we = 1'b0; sel = 4'hF; addr = 32'h8;
    @(posedge clk); #1;
    check("rwait_busy", 32'(bzB), 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("rwait_rst_rdata", rdB, 32'h0);
    check("rwait_rst_err", 32'(erB), 32'd0);
    check("rwait_rst_rvalid", 32'(rvB), 32'd0);
    check("rwait_rst_busy", 32'(bzB), 32'd1);
    @(negedge clk); req = 1'b0;
    rvSeen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (rvB) rvSeen = 1'b1;
    end
    check("rwait_rst_no_rvalid", 32'(rvSeen), 32'd0);

    // reset in the middle of the fill, at fill cycle 7
    @(negedge clk); rst = 1'b1;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midfill_busy", 32'(bzB), 32'd1);
    check("midfill_rvalid", 32'(rvB), 32'd0);
    @(negedge clk); rst = 1'b1;
    countFill(n);
    check("refill_len", n, 32'd16);
    check("refill_no_rvalid", 32'(rvSeen), 32'd0);
    check("refill_c_first_busy", 32'(cFirst), 32'd0);
    doLoad("refillB", 32'h8, 32'h0, 3);
    check("refillB_err", 32'(erB), 32'd0);

    // no-clear configuration round trip after reset
    which = 2;
    doStore(32'h14, 4'hF, 32'h5A5A0FF0);
    doLoad("cRound", 32'h14, 32'h5A5A0FF0, 2);
    check("cRound_err", 32'(erC), 32'd0);
    idle();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
